fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the CPU's program-counter register and drives it through the instruction-memory handshake. Issues one fetch at a time to `imem`, presents the returned instruction to decode over a valid/ready interface, and applies trap and branch/jump redirects, discarding any fetch already in flight. Sits between the EX-stage redirect logic, the hazard unit (stall) and the instruction memory port.

## Interface
- `RESET_VEC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stall` in 1: hazard unit; blocks issue of a new fetch.
- `redir_valid` in 1: branch/jump taken.
- `redir_pc` in 32: branch/jump target.
- `trap_valid` in 1: trap/exception entry; overrides `redir_valid`.
- `trap_pc` in 32: trap vector.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: fetch address, always equals `pc`.
- `imem_rsp_valid` in 1: read data valid, one-cycle pulse.
- `imem_rsp_data` in 32: instruction word.
- `if_valid` out 1: instruction presented to decode.
- `if_ready` in 1: decode accepts.
- `if_pc` out 32: address of presented instruction.
- `if_inst` out 32: presented instruction.
- `pc` out 32: next address to be fetched.
- With `FETCH_TRACE_EN` only: `trace_valid` out 1, `trace_pc` out 32, `trace_cnt` out 32.

## Operation
- States: IDLE, REQ, WAIT, HOLD, KILL. Reset: state IDLE, `pc`=RESET_VEC, `if_valid`=0, `if_pc`=0, `if_inst`=0, `imem_req_valid`=0, trace outputs 0.
- Redirect: `trap_valid` takes priority over `redir_valid`. Target has bits [1:0] forced to 0 and is loaded into `pc` next edge in every state except IDLE. Redirect overrides `stall`.
- IDLE: unconditionally -> REQ next cycle.
- REQ: `imem_req_valid` = ~stall & ~redirect (combinational, not sticky; memory samples only on valid&ready).
  - On handshake: `pc` <= `pc`+4 (32-bit wrap, FFFF_FFFC -> 0000_0000), issued address latched -> WAIT.
  - No handshake: stay.
- WAIT: on `imem_rsp_valid`: `if_inst` <= data, `if_pc` <= issued address, `if_valid` <= 1 -> HOLD.
- HOLD: `if_valid`=1; `if_pc`/`if_inst` stable until `if_valid & if_ready`, then `if_valid` <= 0 -> REQ.
- Redirect by state:
  - REQ: request suppressed -> REQ with new `pc`.
  - WAIT without `imem_rsp_valid`: -> KILL.
  - WAIT with `imem_rsp_valid` same cycle: response discarded -> REQ.
  - HOLD: `if_valid` <= 0 (squash, even if `if_ready`=1 that cycle) -> REQ.
  - KILL: update `pc`, stay KILL.
- KILL: no request. Next `imem_rsp_valid` is discarded -> REQ.
- `imem_rsp_valid` in IDLE/REQ/HOLD is ignored.
- `stall` affects REQ only.

## Timing
- Rst release edge 0: IDLE. Edge 1: REQ, `imem_req_valid` may be high. Fetch accepted at edge N, rsp at edge M>N (memory never responds in the handshake cycle): `if_valid` high from cycle M+1.
- Minimum per-instruction period with 1-cycle memory and `if_ready`=1: 3 cycles (REQ, WAIT, HOLD).
- Async reset mid-operation: all state returns to reset values immediately; an outstanding response after reset release is ignored (state IDLE/REQ).

## Configuration
- `FETCH_TRACE_EN` defined:
  - `trace_valid` pulses 1 cycle registered after each `if_valid & if_ready` handshake, with `trace_pc` = the accepted `if_pc`.
  - `trace_cnt` increments per accepted instruction, wrapping at 2^32.
  - Squashed or discarded instructions are never traced.
- Undefined: trace ports and logic absent; remaining behaviour identical.

## Test plan
- Reset, `imem_req_ready`=1, 1-cycle memory, `if_ready`=1 -> addresses 0,4,8 fetched; `if_pc` 0,4,8 presented every 3 cycles; `pc`=C after third handshake.
- Hold `if_ready`=0 for 5 cycles in HOLD -> `if_valid`, `if_pc`, `if_inst` stable; no new `imem_req_valid`.
- In WAIT, `redir_valid`=1, `redir_pc`=0x103 -> KILL; next rsp discarded (no `if_valid`); next fetch addr 0x100.
- Same cycle `trap_valid` (trap_pc=0x80) and `redir_valid` (0x200) in HOLD -> `if_valid` squashed; next fetch at 0x80.
- `stall`=1 in REQ for 4 cycles -> `imem_req_valid`=0 throughout; `pc` unchanged; fetch resumes on release.
- `FETCH_TRACE_EN`: 3 accepted + 1 squashed instruction -> `trace_cnt`=3, three `trace_valid` pulses with matching `trace_pc`.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem fetch at a time, presents the word to decode.
// Define FETCH_TRACE_EN to add the accepted-instruction trace port (trace_valid_o/trace_pc_o/trace_cnt_o).
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | request pc_q to imem unless stalled or redirected
// WAIT  | fetch accepted, waiting for the response
// HOLD  | instruction presented to decode until accepted
// KILL  | redirected while a fetch was in flight, drop its response
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_pc_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] pc_o
`ifdef FETCH_TRACE_EN
  ,
  output logic        trace_valid_o,
  output logic [31:0] trace_pc_o,
  output logic [31:0] trace_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_KILL = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] addr_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;

  logic        redirect;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic        req_fire;

  // Trap wins over branch; targets are forced word-aligned.
  always_comb begin
    redirect  = trap_valid_i | redir_valid_i;
    redir_raw = trap_valid_i ? trap_pc_i : redir_pc_i;
    redir_tgt = redir_raw & ~32'h0000_0003;
  end

  assign imem_req_valid_o = (state_q == S_REQ) & ~stall_i & ~redirect;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  always_comb begin
    pc_d = pc_q;
    if ((state_q != S_IDLE) && redirect)
      pc_d = redir_tgt;
    else if (req_fire)
      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      addr_q     <= 32'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (req_fire) begin
            addr_q  <= pc_q;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving with the redirect belongs to the old path.
          if (redirect)
            state_q <= imem_rsp_valid_i ? S_REQ : S_KILL;
          else if (imem_rsp_valid_i) begin
            if_inst_q  <= imem_rsp_data_i;
            if_pc_q    <= addr_q;
            if_valid_q <= 1'b1;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect || if_ready_i) begin
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_KILL: begin
          if (imem_rsp_valid_i)
            state_q <= S_REQ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req_addr_o = pc_q;
  assign pc_o            = pc_q;
  assign if_valid_o      = if_valid_q;
  assign if_pc_o         = if_pc_q;
  assign if_inst_o       = if_inst_q;

`ifdef FETCH_TRACE_EN
  logic        accept;
  logic        trace_valid_q;
  logic [31:0] trace_pc_q;
  logic [31:0] trace_cnt_q;

  // A same-cycle redirect squashes the instruction, so it is not traced.
  assign accept = (state_q == S_HOLD) & if_valid_q & if_ready_i & ~redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'd0;
      trace_cnt_q   <= 32'd0;
    end else begin
      trace_valid_q <= accept;
      if (accept) begin
        trace_pc_q  <= if_pc_q;
        trace_cnt_q <= trace_cnt_q + 32'd1;
      end
    end
  end

  assign trace_valid_o = trace_valid_q;
  assign trace_pc_o    = trace_pc_q;
  assign trace_cnt_o   = trace_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Random-stimulus scoreboard bench for fetch_ctrl: a memory model answers fetches with a fixed
// content function, and a PC-stream model predicts which instructions reach decode.
module tb_fetch_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'd0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] pc;
`ifdef FETCH_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_cnt;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_VEC(RV)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .redir_valid_i    (redir_valid),
    .redir_pc_i       (redir_pc),
    .trap_valid_i     (trap_valid),
    .trap_pc_i        (trap_pc),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_pc_o          (if_pc),
    .if_inst_o        (if_inst),
    .pc_o             (pc)
`ifdef FETCH_TRACE_EN
    ,
    .trace_valid_o    (trace_valid),
    .trace_pc_o       (trace_pc),
    .trace_cnt_o      (trace_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 3) == 0)
      return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  // Driver and memory: inputs change 1ns after the rising edge.
  initial begin
    logic        hs_s;
    logic [31:0] hs_addr;
    logic [31:0] mem_addr;
    logic [31:0] stale_addr;
    int          mem_cnt;
    int          stale_cnt;
    int          rst_len;
    int          quiet;
    mem_cnt = 0; stale_cnt = 0; rst_len = 3; quiet = 2;
    mem_addr = 32'd0; stale_addr = 32'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      hs_s    = imem_req_valid & imem_req_ready;
      hs_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (hs_s) begin
        mem_addr = hs_addr;
        mem_cnt  = (cyc < 40) ? 1 : $urandom_range(1, 3);
      end
      if (stale_cnt > 0) begin
        stale_cnt--;
        if (stale_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(stale_addr) ^ 32'hDEAD_0000;
        end
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
        end
      end
      if (!rst) begin
        rst_len--;
        if (rst_len == 0) begin
          rst   = 1'b1;
          quiet = 2;
        end
      end else if (cyc > 40 && $urandom_range(0, 299) == 0) begin
        rst        = 1'b0;
        rst_len    = $urandom_range(1, 2);
        stale_cnt  = mem_cnt;
        stale_addr = mem_addr;
        mem_cnt    = 0;
        quiet      = 2;
      end
      if (cyc < 40) begin
        stall = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
        redir_valid = 1'b0; trap_valid = 1'b0;
      end else begin
        stall          = ($urandom_range(0, 3) == 0);
        imem_req_ready = ($urandom_range(0, 3) != 0);
        if_ready       = ($urandom_range(0, 2) != 0);
        redir_valid    = (quiet == 0) && ($urandom_range(0, 11) == 0);
        trap_valid     = (quiet == 0) && ($urandom_range(0, 24) == 0);
        redir_pc       = rand_tgt();
        trap_pc        = rand_tgt();
      end
      if (quiet > 0) quiet--;
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Reference model: predicts pc and which responses become decode-visible instructions.
  initial begin
    logic [31:0] mpc;
    logic [31:0] oaddr;
    logic [31:0] tgt;
    logic        outst;
    logic        killed;
    logic        redir_o;
    logic        hs_o;
    mpc = RV; oaddr = 32'd0; outst = 1'b0; killed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mpc = RV; outst = 1'b0; killed = 1'b0;
        exp_q.delete();
        check("rst_pc", pc, RV);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      end else begin
        check("pc", pc, mpc);
        redir_o = trap_valid | redir_valid;
        tgt     = (trap_valid ? trap_pc : redir_pc) & ~32'h0000_0003;
        hs_o    = imem_req_valid & imem_req_ready;
        if (stall || redir_o)
          check("req_gate", {31'd0, imem_req_valid}, 32'd0);
        if (imem_rsp_valid && outst) begin
          if (!killed && !redir_o)
            exp_q.push_back('{pc: oaddr, inst: mem_word(oaddr)});
          outst = 1'b0;
        end else if (outst && redir_o) begin
          killed = 1'b1;
        end
        if (hs_o) begin
          check("req_addr", imem_req_addr, mpc);
          check("one_in_flight", {31'd0, (outst || exp_q.size() != 0)}, 32'd0);
          outst  = 1'b1;
          killed = 1'b0;
          oaddr  = mpc;
        end
        if (redir_o)
          mpc = tgt;
        else if (hs_o)
          mpc = mpc + 32'd4;
      end
    end
  end

  // Monitor: pops the expected instruction whenever decode sees one.
  initial begin
    int   wait_cnt;
    logic redir_m;
`ifdef FETCH_TRACE_EN
    logic [31:0] tr_q[$];
    logic [31:0] tr_cnt;
    tr_cnt = 32'd0;
`endif
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wait_cnt = 0;
`ifdef FETCH_TRACE_EN
        tr_q.delete();
        tr_cnt = 32'd0;
        check("rst_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("rst_trace_cnt", trace_cnt, 32'd0);
`endif
      end else begin
`ifdef FETCH_TRACE_EN
        if (trace_valid) begin
          if (tr_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL trace_unexpected: got trace_pc %h, expected no pulse", trace_pc);
          end else begin
            check("trace_pc", trace_pc, tr_q.pop_front());
            check("trace_cnt", trace_cnt, tr_cnt);
          end
        end else if (tr_q.size() != 0) begin
          n_cmp++; n_err++;
          $display("FAIL trace_missing: got no pulse, expected trace_pc %h", tr_q[0]);
          tr_q.delete();
        end
`endif
        redir_m = trap_valid | redir_valid;
        if (if_valid) begin
          wait_cnt = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL if_unexpected: got if_pc %h, expected no instruction", if_pc);
          end else begin
            check("if_pc", if_pc, exp_q[0].pc);
            check("if_inst", if_inst, exp_q[0].inst);
            if (if_ready || redir_m) begin
`ifdef FETCH_TRACE_EN
              if (!redir_m) begin
                tr_q.push_back(exp_q[0].pc);
                tr_cnt = tr_cnt + 32'd1;
              end
`endif
              void'(exp_q.pop_front());
            end
          end
        end else if (exp_q.size() != 0) begin
          wait_cnt++;
          if (wait_cnt >= 2) begin
            n_cmp++; n_err++;
            $display("FAIL if_timeout: got if_valid 0, expected if_pc %h", exp_q[0].pc);
            void'(exp_q.pop_front());
            wait_cnt = 0;
          end
        end
      end
    end
  end

endmodule
